// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the B opcode, the fetch queue entry layout and the
// branch-offset helper used by fetch's early decode.
package cpu_pkg;

  localparam logic [5:0] OPC_B = 6'b000101;
  localparam int CPU_ADDR_W = 64;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // B immediate is a signed word offset; convert to a byte offset.
  function automatic logic [CPU_ADDR_W-1:0] sext26_shl2(input logic [25:0] imm);
    return {{(CPU_ADDR_W-28){imm[25]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO between fetch and decode. Flush empties it in one edge and
// takes priority over push and pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             pop_ok;
  logic             push_ok;

  // Self-protecting: a pop on empty or a push on full without pop is dropped.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PW'(1);
      if (pop_ok)  head <= head + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) mem[tail] <= wdata;
  end

  assign rdata = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, next-PC selection with optional
// early B prediction, and a small queue of fetched {pc, instr} pairs for decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int DEPTH          = 4,
  parameter int PREDICT_UNCOND = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [31:0]            imem_instr,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0]     pc;
  logic [ADDR_W-1:0]     pc_next;
  logic [CPU_ADDR_W-1:0] b_off;
  logic                  pop;
  logic                  push;
  logic                  is_b;
  fetch_entry_t          wr_entry;
  fetch_entry_t          rd_entry;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && ((count < FULL) || pop);
  assign is_b      = (PREDICT_UNCOND != 0) && (imem_instr[31:26] == OPC_B);
  assign b_off     = sext26_shl2(imem_instr[25:0]);

  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = redirect_target;
    else if (push && is_b)
      pc_next = pc + b_off[ADDR_W-1:0];
    else if (push)
      pc_next = pc + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

  always_comb begin
    wr_entry       = '0;
    wr_entry.pc    = CPU_ADDR_W'(pc);
    wr_entry.instr = imem_instr;
  end

  // Redirect is the flush: wrong-path entries never survive the edge.
  fetch_queue #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count)
  );

  assign out_pc    = rd_entry.pc[ADDR_W-1:0];
  assign out_instr = rd_entry.instr;

endmodule
